network_lock_monitor: RTL



---
 rtl/network_lock_monitor_pkg.sv | 10 +
 rtl/edge_sync_detect.sv | 20 ++
 rtl/network_lock_monitor.sv | 89 ++++++++
 3 files changed

// File: rtl/network_lock_monitor_pkg.sv
// network_lock_monitor_pkg: shared FSM encoding and width helper for the lock monitor
package network_lock_monitor_pkg;
    typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/edge_sync_detect.sv
// edge_sync_detect: multi-FF synchroniser followed by a registered rising-edge pulse
module edge_sync_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic [STAGES:0] sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-1:0], d};
            pulse <= sync[STAGES-1] & ~sync[STAGES];
        end
    end
endmodule

// File: rtl/network_lock_monitor.sv
// network_lock_monitor: counts per-node clock edges over a reference gate window
// and declares per-node and network-wide frequency lock.
module network_lock_monitor
    import network_lock_monitor_pkg::*;
#(
    parameter int NODES        = 4,
    parameter int GATE_EDGES   = 16,
    parameter int CNT_WIDTH    = 8,
    parameter int TOL          = 1,
    parameter int LOCK_WINDOWS = 4,
    parameter int SEL_WIDTH    = 2
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_n_i,
    input  logic                        enable_i,
    input  logic                        ref_i,
    input  logic [NODES-1:0]            node_clk_i,
    input  logic [SEL_WIDTH-1:0]        sel_i,
    output logic [NODES-1:0]            locked_o,
    output logic                        all_locked_o,
    output logic signed [CNT_WIDTH:0]   err_o,
    output logic                        window_done_o
);
    localparam int RW = clog2(GATE_EDGES + 1);
    localparam int LW = clog2(LOCK_WINDOWS + 1);
    localparam logic [CNT_WIDTH-1:0] SAT = '1;
    state_t state, state_next;
    logic ref_edge;
    logic [NODES-1:0] node_edge;
    logic [RW-1:0] ref_cnt;
    logic window_end;
    logic signed [CNT_WIDTH:0] err [NODES];
    edge_sync_detect u_ref_sync (
        .clk   (fpga_clk_i),
        .rst_n (reset_n_i),
        .d     (ref_i),
        .pulse (ref_edge)
    );
    always_comb begin
        state_next = state;
        if (!enable_i) state_next = IDLE;
        else if (state == IDLE) state_next = ARM;
        else if (state == ARM && ref_edge) state_next = COUNT;
    end
    // The ARM-exit ref edge opens the window, so GATE_EDGES further edges close it.
    assign window_end = enable_i && state == COUNT && ref_edge && ref_cnt == RW'(GATE_EDGES - 1);
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            ref_cnt       <= '0;
            window_done_o <= 1'b0;
            err_o         <= '0;
        end else begin
            state         <= state_next;
            ref_cnt       <= (!enable_i || state != COUNT || window_end) ? '0 : ref_cnt + RW'(ref_edge);
            window_done_o <= window_end;
            if (window_end) err_o <= err[sel_i];
        end
    end
    for (genvar n = 0; n < NODES; n++) begin : g_node
        logic [CNT_WIDTH-1:0] cnt, fin;
        logic [LW-1:0] lock_cnt;
        logic pass;
        edge_sync_detect u_node_sync (
            .clk   (fpga_clk_i),
            .rst_n (reset_n_i),
            .d     (node_clk_i[n]),
            .pulse (node_edge[n])
        );
        // fin includes an edge coincident with the terminating ref edge
        assign fin    = (cnt == SAT) ? SAT : cnt + CNT_WIDTH'(node_edge[n]);
        assign err[n] = {1'b0, fin} - (CNT_WIDTH + 1)'(GATE_EDGES);
        assign pass   = fin != SAT && err[n] >= -TOL && err[n] <= TOL;
        assign locked_o[n] = lock_cnt == LW'(LOCK_WINDOWS);
        always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt      <= '0;
                lock_cnt <= '0;
            end else if (!enable_i) begin
                cnt      <= '0;
                lock_cnt <= '0;
            end else begin
                cnt <= (state != COUNT || window_end) ? '0 : fin;
                if (window_end) lock_cnt <= pass ? lock_cnt + LW'(lock_cnt != LW'(LOCK_WINDOWS)) : '0;
            end
        end
    end
    assign all_locked_o = &locked_o;
endmodule
